// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer: ALU op codes, command and state enums.
package alu_seq_ctrl_pkg;

  // ALU operation codes. The shift ops move InputA by exactly one bit per cycle.
  localparam logic [2:0] kADD = 3'd0;
  localparam logic [2:0] kLSH = 3'd1;
  localparam logic [2:0] kRSH = 3'd2;
  localparam logic [2:0] kXOR = 3'd3;
  localparam logic [2:0] kAND = 3'd4;

  typedef enum logic [2:0] {
    CMD_ADD = 3'd0,
    CMD_XOR = 3'd1,
    CMD_AND = 3'd2,
    CMD_SHL = 3'd3,
    CMD_SHR = 3'd4,
    CMD_MUL = 3'd5
  } cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StShift,
    StMulAdd,
    StMulSha,
    StMulShb,
    StDone
  } ctrl_state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle command sequencer driving an external single-cycle ALU.
// Supports ADD/XOR/AND, multi-bit shifts and an 8x8 shift-add multiply (low W bits).
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [2:0]   i_cmd_op,
  input  logic [W-1:0] i_cmd_a,
  input  logic [W-1:0] i_cmd_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_result,
  output logic         o_zero,
  output logic [W-1:0] o_alu_a,
  output logic [W-1:0] o_alu_b,
  output logic [2:0]   o_alu_op,
  input  logic [W-1:0] i_alu_out,
  input  logic         i_alu_zero
);

  localparam int unsigned ShamtW = $clog2(W);

  ctrl_state_t     r_state;
  cmd_t            r_op;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_opnd;
  logic [W-1:0]    r_mcand;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]    r_result;
  logic            r_zero;
  logic            r_busy;
  logic            r_done;

  cmd_t            w_cmd;
  logic [W-1:0]    w_alu_a;
  logic [W-1:0]    w_alu_b;
  logic [2:0]      w_alu_op;

  assign w_cmd = cmd_t'(i_cmd_op);

  // Sequencer FSM with registered Busy/Done/Result/ZeroOut.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_op     <= CMD_ADD;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          r_state <= StIdle;
          if (i_start) begin
            r_acc  <= i_cmd_a;
            r_opnd <= i_cmd_b;
            r_op   <= w_cmd;
            case (w_cmd)
              CMD_ADD, CMD_XOR, CMD_AND: begin
                r_state <= StExec;
                r_busy  <= 1'b1;
              end
              CMD_SHL, CMD_SHR: begin
                if (|i_cmd_b[W-1:ShamtW]) begin
                  // Shift distance >= W clears everything.
                  r_result <= '0;
                  r_zero   <= 1'b1;
                  r_state  <= StDone;
                  r_done   <= 1'b1;
                end else if (i_cmd_b[ShamtW-1:0] == '0) begin
                  r_result <= i_cmd_a;
                  r_zero   <= (i_cmd_a == '0);
                  r_state  <= StDone;
                  r_done   <= 1'b1;
                end else begin
                  r_cnt   <= CNT_W'(i_cmd_b[ShamtW-1:0]);
                  r_state <= StShift;
                  r_busy  <= 1'b1;
                end
              end
              CMD_MUL: begin
                r_acc   <= '0;
                r_mcand <= i_cmd_a;
                r_cnt   <= CNT_W'(W);
                r_state <= StMulAdd;
                r_busy  <= 1'b1;
              end
              default: begin
                r_result <= '0;
                r_zero   <= 1'b1;
                r_state  <= StDone;
                r_done   <= 1'b1;
              end
            endcase
          end
        end
        StExec: begin
          r_result <= i_alu_out;
          r_zero   <= (i_alu_out == '0);
          r_state  <= StDone;
          r_done   <= 1'b1;
        end
        StShift: begin
          r_acc <= i_alu_out;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_result <= i_alu_out;
            r_zero   <= (i_alu_out == '0);
            r_state  <= StDone;
            r_done   <= 1'b1;
          end else begin
            r_busy <= 1'b1;
          end
        end
        StMulAdd: begin
          if (r_opnd[0]) r_acc <= i_alu_out;
          r_state <= StMulSha;
          r_busy  <= 1'b1;
        end
        StMulSha: begin
          r_mcand <= i_alu_out;
          r_state <= StMulShb;
          r_busy  <= 1'b1;
        end
        StMulShb: begin
          r_opnd <= i_alu_out;
          r_cnt  <= r_cnt - 1'b1;
          // Exit early once no multiplier bits remain.
          if (i_alu_zero || (r_cnt == CNT_W'(1))) begin
            r_result <= r_acc;
            r_zero   <= (r_acc == '0);
            r_state  <= StDone;
            r_done   <= 1'b1;
          end else begin
            r_state <= StMulAdd;
            r_busy  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // ALU drive decoded from the current state; idle drive is 0 + 0.
  always_comb begin
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_op = kADD;
    case (r_state)
      StExec: begin
        w_alu_a = r_acc;
        w_alu_b = r_opnd;
        case (r_op)
          CMD_XOR: w_alu_op = kXOR;
          CMD_AND: w_alu_op = kAND;
          default: w_alu_op = kADD;
        endcase
      end
      StShift: begin
        w_alu_a  = r_acc;
        w_alu_op = (r_op == CMD_SHL) ? kLSH : kRSH;
      end
      StMulAdd: begin
        if (r_opnd[0]) begin
          w_alu_a = r_acc;
          w_alu_b = r_mcand;
        end
      end
      StMulSha: begin
        w_alu_a  = r_mcand;
        w_alu_op = kLSH;
      end
      StMulShb: begin
        w_alu_a  = r_opnd;
        w_alu_op = kRSH;
      end
      default: ;
    endcase
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_zero   = r_zero;
  assign o_alu_a  = w_alu_a;
  assign o_alu_b  = w_alu_b;
  assign o_alu_op = w_alu_op;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural ALU, command-level latency/result model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       zero;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_out;
  logic       alu_zero;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  alu_seq_ctrl #(.W(8), .CNT_W(4)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_cmd_op   (op),
    .i_cmd_a    (a),
    .i_cmd_b    (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_zero     (zero),
    .o_alu_a    (alu_a),
    .o_alu_b    (alu_b),
    .o_alu_op   (alu_op),
    .i_alu_out  (alu_out),
    .i_alu_zero (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-cycle ALU (shifts move one bit).
  function automatic logic [7:0] alu_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      kADD:    return x + y;
      kLSH:    return {x[6:0], 1'b0};
      kRSH:    return {1'b0, x[7:1]};
      kXOR:    return x ^ y;
      kAND:    return x & y;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_out == 8'h00);

  // Command-level reference: latency (Start cycle to Done cycle) and final result.
  function automatic void calc(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                               output int lat, output logic [7:0] res);
    int nbits;
    case (o)
      3'd0: begin lat = 2; res = x + y; end
      3'd1: begin lat = 2; res = x ^ y; end
      3'd2: begin lat = 2; res = x & y; end
      3'd3, 3'd4: begin
        if (y > 8'd7) begin lat = 1; res = 8'h00; end
        else if (y == 8'd0) begin lat = 1; res = x; end
        else begin
          lat = 1 + int'(y);
          res = (o == 3'd3) ? 8'(int'(x) << y) : 8'(int'(x) >> y);
        end
      end
      3'd5: begin
        nbits = 1;
        for (int i = 0; i < 8; i++) if (y[i]) nbits = i + 1;
        lat = 1 + 3 * nbits;
        res = 8'(int'(x) * int'(y));
      end
      default: begin lat = 1; res = 8'h00; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model state, advanced on every rising edge from the sampled inputs.
  int         m_rem  = 0;
  logic [7:0] m_pend = 8'h00;
  logic [7:0] m_res  = 8'h00;
  logic       m_zero = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;

  initial begin
    int lat;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_rem = 0; m_res = 8'h00; m_zero = 1'b1; m_busy = 1'b0; m_done = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin m_res = m_pend; m_zero = (m_pend == 8'h00); m_done = 1'b1; end
        end else if (start) begin
          calc(op, a, b, lat, m_pend);
          m_rem = lat - 1;
          if (m_rem == 0) begin m_res = m_pend; m_zero = (m_pend == 8'h00); m_done = 1'b1; end
        end
        m_busy = (m_rem > 0);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy",   32'(busy),   32'(m_busy));
        chk("done",   32'(done),   32'(m_done));
        chk("result", 32'(result), 32'(m_res));
        chk("zero",   32'(zero),   32'(m_zero));
        if (!m_busy) begin
          chk("idle_alu_a",  32'(alu_a),  32'h0);
          chk("idle_alu_b",  32'(alu_b),  32'h0);
          chk("idle_alu_op", 32'(alu_op), 32'(kADD));
        end
      end
    end
  end

  // Issue one command and check its Done latency and result against literals.
  task automatic run_cmd(input string name, input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, input int exp_lat, input logic [7:0] exp_res,
                         input int poke);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (poke != 0 && n == poke) begin
        start = 1'b1; op = 3'd0; a = 8'h00; b = 8'h00;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({name, "_lat"},  32'(n),      32'(exp_lat));
    chk({name, "_res"},  32'(result), 32'(exp_res));
    chk({name, "_zero"}, 32'(zero),   32'(exp_res == 8'h00));
  endtask

  initial begin
    int lat;
    logic [7:0] res;
    int ndone;

    rst = 1'b1; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;

    // Pin the model against hand-computed values.
    calc(3'd5, 8'd13, 8'd11, lat, res);
    chk("pin_mul13x11_lat", 32'(lat), 32'd13);
    chk("pin_mul13x11_res", 32'(res), 32'h8F);
    calc(3'd5, 8'd3, 8'h80, lat, res);
    chk("pin_mul3x80_lat", 32'(lat), 32'd25);
    chk("pin_mul3x80_res", 32'(res), 32'h80);
    calc(3'd3, 8'h81, 8'd3, lat, res);
    chk("pin_shl_lat", 32'(lat), 32'd4);
    chk("pin_shl_res", 32'(res), 32'h08);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_done",   32'(done),   32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_zero",   32'(zero),   32'h1);
    chk_en = 1'b1;

    run_cmd("add",      3'd0, 8'hF0, 8'h20, 2,  8'h10, 0);
    run_cmd("shl",      3'd3, 8'h81, 8'd3,  4,  8'h08, 0);
    run_cmd("shr_big",  3'd4, 8'h81, 8'd9,  1,  8'h00, 0);
    run_cmd("shr0",     3'd4, 8'h5A, 8'd0,  1,  8'h5A, 0);
    run_cmd("mul13x11", 3'd5, 8'd13, 8'd11, 13, 8'h8F, 0);
    run_cmd("mul10x10", 3'd5, 8'h10, 8'h10, 16, 8'h00, 0);
    run_cmd("mul3x80",  3'd5, 8'd3,  8'h80, 25, 8'h80, 5);
    run_cmd("xor",      3'd1, 8'hA5, 8'h0F, 2,  8'hAA, 0);
    run_cmd("inv7",     3'd7, 8'h12, 8'h34, 1,  8'h00, 0);

    // Start held through an ADD's DONE: the next command is taken in the DONE cycle.
    run_cmd("and", 3'd2, 8'hCC, 8'hAA, 2, 8'h88, 0);
    @(negedge clk);
    op = 3'd0; a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk);
    op = 3'd7; a = 8'h55; b = 8'h55;
    chk("b2b_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("b2b_done1", 32'(done),   32'h1);
    chk("b2b_res1",  32'(result), 32'h03);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done2", 32'(done),   32'h1);
    chk("b2b_res2",  32'(result), 32'h00);
    chk("b2b_zero2", 32'(zero),   32'h1);

    // Reset held two cycles in the middle of a MUL abandons it.
    run_cmd("add2", 3'd0, 8'h11, 8'h22, 2, 8'h33, 0);
    @(negedge clk);
    op = 3'd5; a = 8'hFF; b = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",   32'(busy),   32'h0);
    chk("midrst_result", 32'(result), 32'h0);
    chk("midrst_zero",   32'(zero),   32'h1);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'h0);

    // Randomized traffic, including Start while busy and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      b     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
